// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave framing stage: default frame widths,
// command-space bases and the framing FSM encoding.
package spi_pkg;

  localparam int DEFAULT_WIDTH_CMD   = 8;
  localparam int DEFAULT_WIDTH_DATA  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Command MSB set selects a read; the register block decodes the rest.
  localparam logic [DEFAULT_WIDTH_CMD-1:0] READ_BASE  = {1'b1, {(DEFAULT_WIDTH_CMD-1){1'b0}}};
  localparam logic [DEFAULT_WIDTH_CMD-1:0] WRITE_BASE = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMD       = 2'd1,
    DATA      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  // Bit counter must reach max(width)+1 so an over-long frame is distinguishable.
  function automatic int cnt_width(input int w_cmd, input int w_data);
    return $clog2(((w_cmd > w_data) ? w_cmd : w_data) + 2);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Pin synchroniser with one history flop; reports the synchronised level and
// single-cycle rise/fall strobes derived from the last two stages.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Resetting to 0 makes a select held low through reset look "already low"
  // rather than a fresh falling edge, so no frame starts from a partial one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave framing stage: oversamples the pins in the clk domain,
// deserialises command/data frames and serialises the read word on spi_sdo.
module spi_slave_phy
  import spi_pkg::*;
#(
  parameter int WIDTH_CMD   = DEFAULT_WIDTH_CMD,
  parameter int WIDTH_DATA  = DEFAULT_WIDTH_DATA,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_scl,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  input  logic                  spi_cs_cmd,
  input  logic                  spi_cs_data,
  input  logic [WIDTH_DATA-1:0] Din,
  output logic [WIDTH_CMD-1:0]  Dcmd,
  output logic [WIDTH_DATA-1:0] Dout,
  output logic                  done_cmd,
  output logic                  done_data,
  output logic                  frame_err
);

  localparam int CNT_W = cnt_width(WIDTH_CMD, WIDTH_DATA);
  localparam logic [CNT_W-1:0] CMD_FULL  = CNT_W'(WIDTH_CMD);
  localparam logic [CNT_W-1:0] CMD_SAT   = CNT_W'(WIDTH_CMD + 1);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(WIDTH_DATA);
  localparam logic [CNT_W-1:0] DATA_SAT  = CNT_W'(WIDTH_DATA + 1);

  logic scl_level, scl_rise, scl_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic cmd_level, cmd_rise, cmd_fall;
  logic data_level, data_rise, data_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .rst(rst), .din(spi_scl),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst(rst), .din(spi_sdi),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_cmd (
    .clk(clk), .rst(rst), .din(spi_cs_cmd),
    .level(cmd_level), .rise(cmd_rise), .fall(cmd_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_data (
    .clk(clk), .rst(rst), .din(spi_cs_data),
    .level(data_level), .rise(data_rise), .fall(data_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{scl_level, sdi_rise, sdi_fall};

  state_t state, next_state;
  logic   start_cmd, start_data;
  logic   done_cmd_d, done_data_d, frame_err_d;

  logic [CNT_W-1:0]      bit_cnt;
  logic [WIDTH_CMD-1:0]  cmd_sr;
  logic [WIDTH_DATA-1:0] rx_sr;
  logic [WIDTH_DATA-1:0] tx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state  = state;
    start_cmd   = 1'b0;
    start_data  = 1'b0;
    done_cmd_d  = 1'b0;
    done_data_d = 1'b0;
    frame_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fall && data_level) begin
          next_state = CMD;
          start_cmd  = 1'b1;
        end else if (data_fall && cmd_level) begin
          next_state = DATA;
          start_data = 1'b1;
        end else if (!cmd_level || !data_level) begin
          // A select that is low without a fresh fall is left over from reset: drain silently.
          next_state  = WAIT_IDLE;
          frame_err_d = cmd_fall | data_fall;
        end
      end
      CMD: begin
        if (data_fall) begin
          next_state  = WAIT_IDLE;
          frame_err_d = 1'b1;
        end else if (cmd_rise) begin
          next_state  = IDLE;
          done_cmd_d  = (bit_cnt == CMD_FULL);
          frame_err_d = (bit_cnt != CMD_FULL);
        end
      end
      DATA: begin
        if (cmd_fall) begin
          next_state  = WAIT_IDLE;
          frame_err_d = 1'b1;
        end else if (data_rise) begin
          next_state  = IDLE;
          done_data_d = (bit_cnt == DATA_FULL);
          frame_err_d = (bit_cnt != DATA_FULL);
        end
      end
      WAIT_IDLE: begin
        if (cmd_level && data_level) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      Dcmd      <= '0;
      Dout      <= '0;
      done_cmd  <= 1'b0;
      done_data <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done_cmd  <= done_cmd_d;
      done_data <= done_data_d;
      frame_err <= frame_err_d;

      // Saturating one past full length keeps an over-long frame from wrapping to "valid".
      if (start_cmd || start_data) begin
        bit_cnt <= '0;
      end else if (scl_rise && state == CMD && bit_cnt != CMD_SAT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (scl_rise && state == DATA && bit_cnt != DATA_SAT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (scl_rise && state == CMD)  cmd_sr <= {cmd_sr[WIDTH_CMD-2:0], sdi_level};
      if (scl_rise && state == DATA) rx_sr  <= {rx_sr[WIDTH_DATA-2:0], sdi_level};

      if (start_data) begin
        tx_sr <= Din;
      end else if (scl_fall && state == DATA) begin
        tx_sr <= {tx_sr[WIDTH_DATA-2:0], 1'b0};
      end

      if (done_cmd_d)  Dcmd <= cmd_sr;
      if (done_data_d) Dout <= rx_sr;
    end
  end

  assign spi_sdo = (state == DATA) & tx_sr[WIDTH_DATA-1];

  done_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({done_cmd, done_data, frame_err}));

endmodule

// File: tb/tb_spi_slave_phy.sv
// Directed bench for spi_slave_phy: drives MCU-side SPI frames and checks the
// framing results, strobe counts and strobe latency against hand-derived values.
module tb_spi_slave_phy;
  import spi_pkg::*;

  localparam int WC = 8;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spi_scl = 1'b0;
  logic          spi_sdi = 1'b0;
  logic          spi_cs_cmd = 1'b1;
  logic          spi_cs_data = 1'b1;
  logic [WD-1:0] Din = '0;
  logic          spi_sdo;
  logic [WC-1:0] Dcmd;
  logic [WD-1:0] Dout;
  logic          done_cmd, done_data, frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_done_cmd = 0, n_done_data = 0, n_err = 0, n_multi = 0;
  int last_done_cmd_cyc = -100, last_done_data_cyc = -100;

  spi_slave_phy #(.WIDTH_CMD(WC), .WIDTH_DATA(WD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_scl(spi_scl), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .spi_cs_cmd(spi_cs_cmd), .spi_cs_data(spi_cs_data),
    .Din(Din), .Dcmd(Dcmd), .Dout(Dout),
    .done_cmd(done_cmd), .done_data(done_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor samples on the falling edge, midway between DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_cmd)  begin n_done_cmd  <= n_done_cmd + 1;  last_done_cmd_cyc  <= cyc; end
      if (done_data) begin n_done_data <= n_done_data + 1; last_done_data_cyc <= cyc; end
      if (frame_err) n_err <= n_err + 1;
      if ((int'(done_cmd) + int'(done_data) + int'(frame_err)) > 1) n_multi <= n_multi + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_drive(input bit is_data, input logic v);
    if (is_data) spi_cs_data = v;
    else         spi_cs_cmd  = v;
  endtask

  // Mode 0: SDI changes while SCL is low, MCU samples SDO just before each rise.
  task automatic spi_bits(input int nbits, input logic [31:0] tx, input int tail,
                          output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_sdi = tx[i];
      if (i != nbits - 1) wait_clks(3);
      rx = {rx[30:0], spi_sdo};
      spi_scl = 1'b1;
      wait_clks(3);
      spi_scl = 1'b0;
    end
    spi_sdi = 1'b0;
    wait_clks(tail);
  endtask

  task automatic spi_frame(input bit is_data, input int nbits, input logic [31:0] tx,
                           input int lead, input int tail, input int gap,
                           output logic [31:0] rx, output int rise_cyc);
    cs_drive(is_data, 1'b0);
    wait_clks(lead);
    spi_bits(nbits, tx, tail, rx);
    cs_drive(is_data, 1'b1);
    rise_cyc = cyc;
    wait_clks(gap);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    wait_clks(3);
    n_checks++; if (Dcmd !== 8'h00)     begin n_fail++; $display("FAIL reset_dcmd: got %h want 00", Dcmd); end
    n_checks++; if (Dout !== 16'h0000)  begin n_fail++; $display("FAIL reset_dout: got %h want 0000", Dout); end
    n_checks++; if (spi_sdo !== 1'b0)   begin n_fail++; $display("FAIL reset_sdo: got %b want 0", spi_sdo); end
    n_checks++; if (done_cmd !== 1'b0)  begin n_fail++; $display("FAIL reset_done_cmd: got %b want 0", done_cmd); end
    n_checks++; if (done_data !== 1'b0) begin n_fail++; $display("FAIL reset_done_data: got %b want 0", done_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst = 1'b0;
    wait_clks(6);
  endtask

  task automatic test_write;
    logic [31:0] rx;
    int rc, dc0, dd0, e0;
    dc0 = n_done_cmd; dd0 = n_done_data; e0 = n_err;
    spi_frame(1'b0, 8, 32'h01, 4, 2, 6, rx, rc);
    n_checks++; if (Dcmd !== 8'h01) begin n_fail++; $display("FAIL write_dcmd: got %h want 01", Dcmd); end
    n_checks++; if (last_done_cmd_cyc - rc !== 3) begin n_fail++; $display("FAIL write_cmd_latency: got %0d want 3", last_done_cmd_cyc - rc); end
    spi_frame(1'b1, 16, 32'hA5C3, 4, 2, 6, rx, rc);
    n_checks++; if (Dout !== 16'hA5C3) begin n_fail++; $display("FAIL write_dout: got %h want a5c3", Dout); end
    n_checks++; if (n_done_cmd - dc0 !== 1)  begin n_fail++; $display("FAIL write_done_cmd_count: got %0d want 1", n_done_cmd - dc0); end
    n_checks++; if (n_done_data - dd0 !== 1) begin n_fail++; $display("FAIL write_done_data_count: got %0d want 1", n_done_data - dd0); end
    n_checks++; if (n_err - e0 !== 0)        begin n_fail++; $display("FAIL write_err_count: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_read;
    logic [31:0] rx;
    logic [7:0]  rd_cmd;
    int rc, dd0, e0;
    dd0 = n_done_data; e0 = n_err;
    rd_cmd = READ_BASE | 8'h02;
    spi_frame(1'b0, 8, {24'h0, rd_cmd}, 4, 2, 6, rx, rc);
    n_checks++; if (Dcmd !== 8'h82) begin n_fail++; $display("FAIL read_dcmd: got %h want 82", Dcmd); end
    Din = 16'h1234;
    spi_frame(1'b1, 16, 32'h5A5A, 4, 2, 6, rx, rc);
    n_checks++; if (rx[15:0] !== 16'h1234) begin n_fail++; $display("FAIL read_sdo_word: got %h want 1234", rx[15:0]); end
    n_checks++; if (spi_sdo !== 1'b0)      begin n_fail++; $display("FAIL read_sdo_idle: got %b want 0", spi_sdo); end
    n_checks++; if (Dout !== 16'h5A5A)     begin n_fail++; $display("FAIL read_dout: got %h want 5a5a", Dout); end
    n_checks++; if (n_done_data - dd0 !== 1) begin n_fail++; $display("FAIL read_done_data_count: got %0d want 1", n_done_data - dd0); end
    n_checks++; if (n_err - e0 !== 0)        begin n_fail++; $display("FAIL read_err_count: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_short_long;
    logic [31:0] rx;
    int rc, dc0, dd0, e0;
    dc0 = n_done_cmd; dd0 = n_done_data; e0 = n_err;
    spi_frame(1'b0, 7, 32'h7F, 4, 2, 6, rx, rc);
    spi_frame(1'b1, 17, 32'h1FFFF, 4, 2, 6, rx, rc);
    n_checks++; if (n_err - e0 !== 2)        begin n_fail++; $display("FAIL shortlong_err_count: got %0d want 2", n_err - e0); end
    n_checks++; if (n_done_cmd - dc0 !== 0)  begin n_fail++; $display("FAIL shortlong_done_cmd: got %0d want 0", n_done_cmd - dc0); end
    n_checks++; if (n_done_data - dd0 !== 0) begin n_fail++; $display("FAIL shortlong_done_data: got %0d want 0", n_done_data - dd0); end
    n_checks++; if (Dcmd !== 8'h82)          begin n_fail++; $display("FAIL shortlong_dcmd: got %h want 82", Dcmd); end
    n_checks++; if (Dout !== 16'h5A5A)       begin n_fail++; $display("FAIL shortlong_dout: got %h want 5a5a", Dout); end
  endtask

  task automatic test_both_cs;
    logic [31:0] rx;
    int rc, dc0, dd0, e0;
    dc0 = n_done_cmd; dd0 = n_done_data; e0 = n_err;
    spi_cs_cmd  = 1'b0;
    spi_cs_data = 1'b0;
    wait_clks(10);
    n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL both_err_count: got %0d want 1", n_err - e0); end
    spi_cs_cmd  = 1'b1;
    spi_cs_data = 1'b1;
    wait_clks(6);
    n_checks++; if ((n_done_cmd - dc0) + (n_done_data - dd0) !== 0) begin n_fail++; $display("FAIL both_no_done: got %0d want 0", (n_done_cmd - dc0) + (n_done_data - dd0)); end
    spi_frame(1'b0, 8, 32'h03, 4, 2, 6, rx, rc);
    n_checks++; if (Dcmd !== 8'h03)         begin n_fail++; $display("FAIL both_next_dcmd: got %h want 03", Dcmd); end
    n_checks++; if (n_done_cmd - dc0 !== 1) begin n_fail++; $display("FAIL both_next_done_cmd: got %0d want 1", n_done_cmd - dc0); end
    n_checks++; if (n_err - e0 !== 1)       begin n_fail++; $display("FAIL both_err_total: got %0d want 1", n_err - e0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rx;
    int rc, dc0, dd0, e0;
    dc0 = n_done_cmd; dd0 = n_done_data; e0 = n_err;
    Din = 16'hBEEF;
    spi_cs_data = 1'b0;
    wait_clks(4);
    spi_bits(8, 32'hAB, 3, rx);
    rst = 1'b1;
    wait_clks(2);
    n_checks++; if (Dcmd !== 8'h00)    begin n_fail++; $display("FAIL midrst_dcmd: got %h want 00", Dcmd); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL midrst_dout: got %h want 0000", Dout); end
    n_checks++; if (spi_sdo !== 1'b0)  begin n_fail++; $display("FAIL midrst_sdo: got %b want 0", spi_sdo); end
    rst = 1'b0;
    spi_bits(8, 32'hCD, 2, rx);
    spi_cs_data = 1'b1;
    wait_clks(8);
    n_checks++; if ((n_done_cmd - dc0) + (n_done_data - dd0) + (n_err - e0) !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d want 0", (n_done_cmd - dc0) + (n_done_data - dd0) + (n_err - e0)); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL midrst_dout_after: got %h want 0000", Dout); end
    n_checks++; if (spi_sdo !== 1'b0)  begin n_fail++; $display("FAIL midrst_sdo_after: got %b want 0", spi_sdo); end
    spi_frame(1'b1, 16, 32'hFFFF, 4, 2, 6, rx, rc);
    n_checks++; if (Dout !== 16'hFFFF)       begin n_fail++; $display("FAIL midrst_next_dout: got %h want ffff", Dout); end
    n_checks++; if (n_done_data - dd0 !== 1) begin n_fail++; $display("FAIL midrst_next_done: got %0d want 1", n_done_data - dd0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx;
    int rc_cmd, rc_data, dc0, dd0, e0;
    dc0 = n_done_cmd; dd0 = n_done_data; e0 = n_err;
    spi_frame(1'b0, 8, 32'h02, 4, 2, 2, rx, rc_cmd);
    spi_frame(1'b1, 16, 32'h0F0F, 4, 2, 6, rx, rc_data);
    n_checks++; if (last_done_cmd_cyc - rc_cmd !== 3)   begin n_fail++; $display("FAIL b2b_cmd_latency: got %0d want 3", last_done_cmd_cyc - rc_cmd); end
    n_checks++; if (last_done_data_cyc - rc_data !== 3) begin n_fail++; $display("FAIL b2b_data_latency: got %0d want 3", last_done_data_cyc - rc_data); end
    n_checks++; if (Dcmd !== 8'h02)    begin n_fail++; $display("FAIL b2b_dcmd: got %h want 02", Dcmd); end
    n_checks++; if (Dout !== 16'h0F0F) begin n_fail++; $display("FAIL b2b_dout: got %h want 0f0f", Dout); end
    n_checks++; if ((n_done_cmd - dc0) + (n_done_data - dd0) !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", (n_done_cmd - dc0) + (n_done_data - dd0)); end
    n_checks++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_count: got %0d want 0", n_err - e0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_short_long();
    test_both_cs();
    test_reset_mid_frame();
    test_back_to_back();
    n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", n_multi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_phy.md
Name: spi_slave_phy

Overview:
SPI slave physical/framing stage. It sits directly upstream of the register-interface block. It oversamples the raw SPI pins in the system clock domain and deserialises command frames (on spi_cs_cmd) and data frames (on spi_cs_data). It hands the register-interface block a command byte, a data word and one-cycle done strobes, and serialises the read word back on spi_sdo.

Parameters:
WIDTH_CMD, 8, command frame length in bits
WIDTH_DATA, 16, data frame length in bits
SYNC_STAGES, 2, flip-flop stages in each pin synchroniser (min 2)

Ports:
clk  input  1  system clock; the single clock of the block
rst  input  1  asynchronous, active-high reset
spi_scl  input  1  SPI clock from MCU, asynchronous to clk
spi_sdi  input  1  serial data from MCU
spi_sdo  output  1  serial data to MCU
spi_cs_cmd  input  1  active-low select, command frame
spi_cs_data  input  1  active-low select, data frame
Din  input  WIDTH_DATA  read word from register interface, sampled at data-frame start
Dcmd  output  WIDTH_CMD  last valid command byte, held
Dout  output  WIDTH_DATA  last valid write word, held
done_cmd  output  1  1-clk pulse: valid command frame completed
done_data  output  1  1-clk pulse: valid data frame completed
frame_err  output  1  1-clk pulse: frame discarded

Behaviour:
- SPI mode 0, MSB first. SDI is captured on the detected SCL rise. SDO shifts on the detected SCL fall.
- Every pin passes through a SYNC_STAGES synchroniser plus one history flop. Edges are detected from the last two stages.
- Timing constraints on the MCU side:
  - SCL high and low each >= 3 clk periods.
  - CS fall to first SCL rise >= 4 clk periods.
  - Last SCL fall to CS rise >= 2 clk periods.
- Reset values: Dcmd=0, Dout=0, spi_sdo=0, done_cmd=0, done_data=0, frame_err=0, bit counter=0, FSM=IDLE.
- FSM states: IDLE, CMD, DATA, WAIT_IDLE.
  - IDLE -> CMD on detected cs_cmd fall while cs_data is high.
  - IDLE -> DATA on detected cs_data fall while cs_cmd is high.
  - IDLE with both CS low -> WAIT_IDLE, and frame_err pulses.
- CMD state: shift SDI into the cmd shift register on each SCL rise and count bits (the counter saturates at WIDTH_CMD+1).
  - On cs_cmd rise with count==WIDTH_CMD: Dcmd <= shift register, done_cmd pulses. Go to IDLE.
  - On cs_cmd rise with any other count: Dcmd unchanged, frame_err pulses. Go to IDLE.
- DATA state:
  - On entry, load the tx shift register from Din. spi_sdo = tx MSB. Shift left on each SCL fall, filling with 0.
  - The rx shift register captures SDI on each SCL rise.
  - On cs_data rise with count==WIDTH_DATA: Dout <= rx shift register, done_data pulses. Go to IDLE.
  - On cs_data rise with any other count: frame_err pulses, Dout unchanged. Go to IDLE.
- The rx path always captures, so a read frame also updates Dout. The downstream block decodes writes from Dcmd.
- Other CS falls during CMD or DATA -> WAIT_IDLE, frame_err pulses.
- WAIT_IDLE -> IDLE once both synchronised CS are high.
- spi_sdo = 0 outside DATA.
- Latency: done_cmd, done_data and frame_err assert on the 3rd clk rising edge after the first edge that samples the CS rise (with SYNC_STAGES=2).
- Dcmd is stable when done_cmd pulses and holds until the next valid command frame. Din must be valid from done_cmd+1 until the next data-frame start.
- Reset mid-frame: everything returns to reset values.
  - If either CS is low when rst deasserts, go to WAIT_IDLE with no done or err pulse.
  - No partial frame is ever reported.
- done_cmd, done_data and frame_err are mutually exclusive in any cycle.

Decomposition:
- Package spi_pkg holds WIDTH_CMD and WIDTH_DATA defaults, READ_BASE = 1<<(WIDTH_CMD-1), WRITE_BASE = 0, and the FSM state encoding.
- Sub-module sync_edge (SYNC_STAGES flops plus history flop; outputs level, rise, fall) is instantiated 4x: scl, sdi, cs_cmd, cs_data.

Test Plan:
- Write: cmd frame 0x01, then data frame 0xA5C3 -> done_cmd with Dcmd=0x01, then done_data with Dout=0xA5C3; exactly one pulse each; frame_err never set.
- Read: cmd 0x82, Din=0x1234 driven after done_cmd, 16 SCL cycles on cs_data -> MCU samples 0x1234 MSB first on SCL rises; spi_sdo=0 after cs_data rises.
- Short/long frame: cmd frame of 7 bits, then data frame of 17 bits -> two frame_err pulses, no done pulses; Dcmd and Dout keep their prior values.
- Both CS low simultaneously from IDLE -> single frame_err; no done until both are high; the next valid cmd 0x03 is accepted.
- rst pulse after 8 bits of a data frame, with cs_data still low -> all outputs 0, remaining bits ignored, no done or err; the next full frame 0xFFFF -> Dout=0xFFFF.
- Back-to-back: cmd 0x02 and data 0x0F0F with minimum CS gaps at SCL = clk/6 -> done_cmd latency exactly 3 clk after CS rise; Dout=0x0F0F.
